// File: rtl/eth_rx_frame_fifo.sv
`timescale 1ns/1ps
// Store-and-forward Ethernet receive buffer: commits clean frames, rewinds rejected ones.
// Define ETH_RX_ADDR_FILTER_EN to drop frames whose destination is neither LOCAL_MAC nor broadcast.
//
// state | meaning
// IDLE  | waiting for the first byte of a frame
// WRITE | storing frame bytes speculatively past wr_commit
// DROP  | discarding the rest of a rejected frame until tlast
module eth_rx_frame_fifo #(
  parameter int          ADDR_W    = 11,
  parameter logic [47:0] LOCAL_MAC = 48'h000A35000001
) (
  input  logic              clk_mac,
  input  logic              rst,
  input  logic [7:0]        rx_axis_mac_tdata,
  input  logic              rx_axis_mac_tvalid,
  input  logic              rx_axis_mac_tlast,
  input  logic              rx_axis_mac_tuser,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [15:0]       cnt_ok,
  output logic [15:0]       cnt_drop_err,
  output logic [15:0]       cnt_drop_ovf,
  output logic [15:0]       cnt_drop_filt,
  output logic [ADDR_W:0]   buf_level
);

  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE = 1;
`ifdef ETH_RX_ADDR_FILTER_EN
  localparam logic FILT_EN = 1'b1;
`else
  localparam logic FILT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} state_t;
  typedef enum logic [1:0] {C_ERR, C_OVF, C_FILT} cause_t;

  logic [8:0]      r_mem [0:(1<<ADDR_W)-1];
  state_t          r_state, w_state_nxt;
  cause_t          r_cause, w_cause_nxt;
  logic [ADDR_W:0] r_wr_ptr, r_wr_commit, r_rd_ptr;
  logic [ADDR_W:0] w_wr_ptr_nxt, w_wr_commit_nxt;
  logic [2:0]      r_byte_cnt, w_byte_cnt_nxt;
  logic            r_match_local, r_match_bcast;
  logic            w_match_local_nxt, w_match_bcast_nxt;
  logic [15:0]     r_cnt_ok, r_cnt_err, r_cnt_ovf, r_cnt_filt;
  logic            r_out_valid, r_out_last;
  logic [7:0]      r_out_data;

  logic [2:0] w_idx;
  logic [7:0] w_mac_byte;
  logic       w_runt, w_full, w_hit_local, w_hit_bcast, w_filt_fail;
  logic       w_we, w_inc_ok, w_inc_err, w_inc_ovf, w_inc_filt;
  logic       w_xfer, w_rd_en;

  // Index of the incoming byte within its frame; saturates once past the address field.
  assign w_idx  = (r_state == S_WRITE) ? r_byte_cnt : 3'd0;
  assign w_runt = (w_idx < 3'd5);
  assign w_full = ((r_wr_ptr - r_rd_ptr) == DEPTH);

  always_comb begin
    w_mac_byte = 8'h00;
    case (w_idx)
      3'd0:    w_mac_byte = LOCAL_MAC[47:40];
      3'd1:    w_mac_byte = LOCAL_MAC[39:32];
      3'd2:    w_mac_byte = LOCAL_MAC[31:24];
      3'd3:    w_mac_byte = LOCAL_MAC[23:16];
      3'd4:    w_mac_byte = LOCAL_MAC[15:8];
      3'd5:    w_mac_byte = LOCAL_MAC[7:0];
      default: w_mac_byte = 8'h00;
    endcase
  end

  assign w_hit_local = ((r_state == S_IDLE) || r_match_local) && (rx_axis_mac_tdata == w_mac_byte);
  assign w_hit_bcast = ((r_state == S_IDLE) || r_match_bcast) && (rx_axis_mac_tdata == 8'hFF);
  assign w_filt_fail = FILT_EN && (w_idx == 3'd5) && !w_hit_local && !w_hit_bcast;

  always_comb begin
    w_state_nxt       = r_state;
    w_cause_nxt       = r_cause;
    w_wr_ptr_nxt      = r_wr_ptr;
    w_wr_commit_nxt   = r_wr_commit;
    w_byte_cnt_nxt    = r_byte_cnt;
    w_match_local_nxt = r_match_local;
    w_match_bcast_nxt = r_match_bcast;
    w_we              = 1'b0;
    w_inc_ok          = 1'b0;
    w_inc_err         = 1'b0;
    w_inc_ovf         = 1'b0;
    w_inc_filt        = 1'b0;
    case (r_state)
      S_IDLE, S_WRITE: begin
        if (rx_axis_mac_tvalid) begin
          w_byte_cnt_nxt    = (w_idx == 3'd7) ? 3'd7 : w_idx + 3'd1;
          w_match_local_nxt = w_hit_local;
          w_match_bcast_nxt = w_hit_bcast;
          if (rx_axis_mac_tlast) begin
            w_state_nxt  = S_IDLE;
            w_wr_ptr_nxt = r_wr_commit;
            if (rx_axis_mac_tuser || w_runt) w_inc_err = 1'b1;
            else if (w_full)                 w_inc_ovf = 1'b1;
            else if (w_filt_fail)            w_inc_filt = 1'b1;
            else begin
              w_we            = 1'b1;
              w_inc_ok        = 1'b1;
              w_wr_ptr_nxt    = r_wr_ptr + PTR_ONE;
              w_wr_commit_nxt = r_wr_ptr + PTR_ONE;
            end
          end else if (w_full) begin
            w_state_nxt  = S_DROP;
            w_cause_nxt  = C_OVF;
            w_wr_ptr_nxt = r_wr_commit;
          end else if (w_filt_fail) begin
            w_state_nxt  = S_DROP;
            w_cause_nxt  = C_FILT;
            w_wr_ptr_nxt = r_wr_commit;
          end else begin
            w_state_nxt  = S_WRITE;
            w_we         = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
          end
        end
      end
      S_DROP: begin
        if (rx_axis_mac_tvalid && rx_axis_mac_tlast) begin
          w_state_nxt = S_IDLE;
          w_inc_err   = (r_cause == C_ERR);
          w_inc_ovf   = (r_cause == C_OVF);
          w_inc_filt  = (r_cause == C_FILT);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Prefetch into the output register whenever it is empty or being emptied this cycle.
  assign w_xfer  = r_out_valid && m_axis_tready;
  assign w_rd_en = (r_rd_ptr != r_wr_commit) && (!r_out_valid || w_xfer);

  always_ff @(posedge clk_mac) begin
    if (!rst && w_we) r_mem[r_wr_ptr[ADDR_W-1:0]] <= {rx_axis_mac_tlast, rx_axis_mac_tdata};
  end

  always_ff @(posedge clk_mac) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cause       <= C_ERR;
      r_wr_ptr      <= '0;
      r_wr_commit   <= '0;
      r_rd_ptr      <= '0;
      r_byte_cnt    <= 3'd0;
      r_match_local <= 1'b0;
      r_match_bcast <= 1'b0;
      r_cnt_ok      <= 16'd0;
      r_cnt_err     <= 16'd0;
      r_cnt_ovf     <= 16'd0;
      r_cnt_filt    <= 16'd0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_data    <= 8'h00;
    end else begin
      r_state       <= w_state_nxt;
      r_cause       <= w_cause_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_wr_commit   <= w_wr_commit_nxt;
      r_byte_cnt    <= w_byte_cnt_nxt;
      r_match_local <= w_match_local_nxt;
      r_match_bcast <= w_match_bcast_nxt;
      if (w_inc_ok   && r_cnt_ok   != 16'hFFFF) r_cnt_ok   <= r_cnt_ok   + 16'd1;
      if (w_inc_err  && r_cnt_err  != 16'hFFFF) r_cnt_err  <= r_cnt_err  + 16'd1;
      if (w_inc_ovf  && r_cnt_ovf  != 16'hFFFF) r_cnt_ovf  <= r_cnt_ovf  + 16'd1;
      if (w_inc_filt && r_cnt_filt != 16'hFFFF) r_cnt_filt <= r_cnt_filt + 16'd1;
      if (w_rd_en) begin
        {r_out_last, r_out_data} <= r_mem[r_rd_ptr[ADDR_W-1:0]];
        r_out_valid              <= 1'b1;
        r_rd_ptr                 <= r_rd_ptr + PTR_ONE;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_out_data;
  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tlast  = r_out_last;
  assign cnt_ok        = r_cnt_ok;
  assign cnt_drop_err  = r_cnt_err;
  assign cnt_drop_ovf  = r_cnt_ovf;
  assign cnt_drop_filt = r_cnt_filt;
  assign buf_level     = r_wr_commit - r_rd_ptr;

endmodule

// File: doc/eth_rx_frame_fifo.md
# eth_rx_frame_fifo

Store-and-forward receive buffer between the MAC receive stream (`rx_axis_mac_*`) and user logic on `clk_mac`. It writes each incoming frame into a circular byte buffer. Only frames that end clean are committed; errored, overflowed and (optionally) mis-addressed frames are rewound and discarded. Committed frames are replayed on a backpressurable AXI-Stream master, and per-cause drop counts are exported for the MDIO/LED debug logic.

## Interface
Parameters:
- `ADDR_W`, 11: buffer depth is 2^ADDR_W bytes; pointers are ADDR_W+1 bits.
- `LOCAL_MAC`, 48'h000A35000001: unicast address accepted by the filter; byte 0 is bits [47:40].

Ports:
- `clk_mac`  in  1  sole clock, 50 MHz MAC clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_axis_mac_tdata`  in  8  received byte.
- `rx_axis_mac_tvalid`  in  1  byte valid; there is no backpressure.
- `rx_axis_mac_tlast`  in  1  last byte of frame.
- `rx_axis_mac_tuser`  in  1  frame error, sampled with tlast.
- `m_axis_tdata`  out  8  output byte.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tlast`  out  1  last byte of committed frame.
- `m_axis_tready`  in  1  downstream ready.
- `cnt_ok`  out  16  committed frames, saturating.
- `cnt_drop_err`  out  16  frames dropped for tuser or runt, saturating.
- `cnt_drop_ovf`  out  16  frames dropped for buffer full, saturating.
- `cnt_drop_filt`  out  16  frames dropped by the address filter, saturating.
- `buf_level`  out  ADDR_W+1  committed bytes not yet read, equal to `wr_commit - rd_ptr`.

## Operation
- Storage: RAM of 2^ADDR_W × 9 bits, holding {tlast, data}.
- Pointers:
  - `wr_ptr` is the speculative write pointer.
  - `wr_commit` marks the end of the last committed frame.
  - `rd_ptr` is the read pointer.
  - All three are ADDR_W+1 bits and wrap modulo 2^(ADDR_W+1).
- Write FSM states:
  - IDLE: on tvalid, write the byte, set byte_cnt=1, go to WRITE. If tlast is also set, apply the tlast rule below.
  - WRITE: each tvalid byte is written at `wr_ptr`, then `wr_ptr` and byte_cnt increment. Byte_cnt saturates at 7.
  - DROP: tvalid bytes are ignored. On tvalid&tlast, go to IDLE and increment the pending cause counter.
- Full condition: `wr_ptr - rd_ptr == 2^ADDR_W`. An incoming byte while full sets cause=ovf and sends the FSM to DROP. `wr_ptr` rewinds to `wr_commit`.
- tlast rule, for a byte in IDLE or WRITE, with cause priority err > ovf > filt:
  - Drop with cause err if tuser=1 or the frame is shorter than 6 bytes.
  - Drop with cause filt on a filter mismatch (see Configuration).
  - Otherwise write the byte with the tlast bit set, set `wr_commit <= wr_ptr+1` and increment `cnt_ok`.
  - On any drop, `wr_ptr <= wr_commit` and the cause counter increments.
  - The FSM returns to IDLE.
- Exactly one counter increments per frame. Counters saturate at 16'hFFFF.
- Read side:
  - Reads are prefetched into a one-entry output register.
  - `m_axis_tvalid` is 1 whenever the output register is full.
  - A RAM read is issued when `rd_ptr != wr_commit` and either the output register is empty or a transfer (tvalid&tready) occurs this cycle.
- Reset: all pointers go to 0, the FSM to IDLE and the counters to 0, and any partial frame is discarded. A byte arriving in the first cycle after reset starts a new frame.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, all `cnt_*`=0, `buf_level`=0.
- Commit to first output: `m_axis_tvalid` rises 2 cycles after the cycle in which the tlast byte is accepted, when the buffer was previously empty.
- Throughput: 1 byte per cycle while tready is held high. There are no bubbles within or between committed frames.
- Handshake: `m_axis_tdata` and `m_axis_tlast` are stable while tvalid=1 and tready=0. tvalid never drops without a transfer.
- Simultaneous commit and read: the read side sees the new `wr_commit` on the next cycle. A read freeing space in the same cycle as a full check is not credited until the next cycle.
- Counters and `buf_level` update 1 cycle after the causing event.

## Configuration
- `ETH_RX_ADDR_FILTER_EN` defined:
  - Bytes 0–5 are compared against `LOCAL_MAC` and against FF:FF:FF:FF:FF:FF.
  - If both comparisons have failed by byte 5, the frame goes to DROP with cause filt. Bytes already written are rewound.
- Undefined: no comparison is performed and all error-free frames of 6 bytes or more are committed. `cnt_drop_filt` stays 0.

## Test plan
- 64-byte broadcast frame, tuser=0, tready=1 → the identical 64 bytes out, tlast on byte 63, `cnt_ok`=1, first tvalid 2 cycles after the input tlast.
- 64-byte frame with tuser=1 on tlast → no output, `cnt_drop_err`=1, `buf_level`=0; a following good frame comes out intact.
- ADDR_W=6, tready=0, three 30-byte frames → frames 1–2 committed, frame 3 dropped, `cnt_drop_ovf`=1. After tready=1, 60 bytes out with 2 tlasts.
- Filter enabled: dest 02:00:00:00:00:09 → `cnt_drop_filt`=1, no output. Dest = LOCAL_MAC → passed. Filter disabled: both passed.
- Random tready on 20 back-to-back frames of length 6–1500 → byte-exact, in order, data stable under stall.
- `rst` pulsed mid-frame → all outputs 0 the next cycle; the next full frame is passed with `cnt_ok`=1.
